// File: rtl/jc_phase_decoder_pkg.sv
// Shared Johnson-domain definitions: tracker FSM states, index width helper and defaults.
package jc_pkg;

  localparam int unsigned JC_W_DEFAULT        = 64;
  localparam int unsigned JC_LOCK_CNT_DEFAULT = 4;
  localparam int unsigned JC_ERR_W_DEFAULT    = 8;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } jc_state_t;

  // Bits needed to hold a phase index in a 2*w state Johnson code space.
  function automatic int unsigned idx_w(input int unsigned w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/jc_phase_decoder_if.sv
// Sample/status bundle between a Johnson counter source and jc_phase_decoder.
// Optional phase_onehot member exists only when JC_PHASE_ONEHOT_EN is defined.
interface jc_phase_decoder_if
  import jc_pkg::*;
#(
  parameter int unsigned W     = JC_W_DEFAULT,
  parameter int unsigned ERR_W = JC_ERR_W_DEFAULT
);
  localparam int unsigned IDX_W = idx_w(W);

  logic             jc_valid;
  logic [W-1:0]     jc_q;
  logic [IDX_W-1:0] phase_idx;
  logic             phase_valid;
  logic             locked;
  logic             wrap;
  logic             err_illegal;
  logic             err_skip;
  logic [ERR_W-1:0] err_cnt;
`ifdef JC_PHASE_ONEHOT_EN
  logic [2*W-1:0]   phase_onehot;
`endif

  modport master (
    output jc_valid, jc_q,
    input  phase_idx, phase_valid, locked, wrap, err_illegal, err_skip, err_cnt
`ifdef JC_PHASE_ONEHOT_EN
    , input phase_onehot
`endif
  );

  modport slave (
    input  jc_valid, jc_q,
    output phase_idx, phase_valid, locked, wrap, err_illegal, err_skip, err_cnt
`ifdef JC_PHASE_ONEHOT_EN
    , output phase_onehot
`endif
  );

endinterface

// File: rtl/jc_phase_decoder_code_check.sv
// Combinational Johnson-code legality check and phase index decode for one W-bit word.
module jc_code_check
  import jc_pkg::*;
#(
  parameter int unsigned W = JC_W_DEFAULT
) (
  input  logic [W-1:0]        q,
  output logic                legal,
  output logic [idx_w(W)-1:0] idx
);
  localparam int unsigned IDX_W = idx_w(W);
  localparam int unsigned POP_W = $clog2(W + 1);

  logic [W-2:0]     trans;
  logic [POP_W-1:0] pop;

  // A legal word has at most one boundary between its run of ones and zeros.
  assign trans = q[W-2:0] ^ q[W-1:1];
  assign legal = ((trans & (trans - 1'b1)) == '0);

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pop = pop + POP_W'(q[i]);
    end
  end

  always_comb begin
    idx = '0;
    if (q == '0) begin
      idx = '0;
    end else if (q[W-1]) begin
      idx = IDX_W'(pop);
    end else begin
      idx = IDX_W'((IDX_W+1)'(2 * W) - (IDX_W+1)'(pop));
    end
  end

endmodule

// File: rtl/jc_phase_decoder.sv
// Two-stage Johnson counter phase decoder with lock/track/fault supervision.
// Build option JC_PHASE_ONEHOT_EN adds a registered one-hot phase output.
module jc_phase_decoder
  import jc_pkg::*;
#(
  parameter int unsigned W        = JC_W_DEFAULT,
  parameter int unsigned LOCK_CNT = JC_LOCK_CNT_DEFAULT,
  parameter int unsigned ERR_W    = JC_ERR_W_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  jc_phase_decoder_if.slave  bus
);
  localparam int unsigned IDX_W = idx_w(W);
  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(2 * W - 1);

  logic             chk_legal;
  logic [IDX_W-1:0] chk_idx;

  logic             s1_valid, s1_legal;
  logic [IDX_W-1:0] s1_idx;

  jc_state_t        state, state_n;
  logic [IDX_W-1:0] ref_idx, ref_n, succ_idx;
  logic [CNT_W-1:0] lock_cnt, cnt_n;
  logic [IDX_W-1:0] idx_n;
  logic             pv_n, wrap_n, ill_n, skip_n;
  logic [ERR_W-1:0] err_cnt_n;
  logic             is_succ;

  jc_code_check #(.W(W)) u_check (
    .q     (bus.jc_q),
    .legal (chk_legal),
    .idx   (chk_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_legal <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= bus.jc_valid;
      if (bus.jc_valid) begin
        s1_legal <= chk_legal;
        s1_idx   <= chk_idx;
      end
    end
  end

  assign succ_idx = (ref_idx == IDX_MAX) ? '0 : ref_idx + 1'b1;
  assign is_succ  = (s1_idx == succ_idx);

  always_comb begin
    state_n   = state;
    ref_n     = ref_idx;
    cnt_n     = lock_cnt;
    idx_n     = bus.phase_idx;
    pv_n      = 1'b0;
    wrap_n    = 1'b0;
    ill_n     = 1'b0;
    skip_n    = 1'b0;
    err_cnt_n = bus.err_cnt;
    if (s1_valid) begin
      idx_n = s1_idx;
      unique case (state)
        UNLOCK: begin
          if (!s1_legal) begin
            cnt_n = '0;
          end else begin
            ref_n = s1_idx;
            cnt_n = (lock_cnt == '0 || !is_succ) ? CNT_W'(1) : lock_cnt + 1'b1;
            if (cnt_n == CNT_W'(LOCK_CNT)) begin
              state_n = TRACK;
              pv_n    = 1'b1;
            end
          end
        end
        TRACK: begin
          if (!s1_legal || !is_succ) begin
            ill_n   = !s1_legal;
            skip_n  = s1_legal;
            state_n = FAULT;
            if (bus.err_cnt != '1) err_cnt_n = bus.err_cnt + 1'b1;
          end else begin
            ref_n  = s1_idx;
            pv_n   = 1'b1;
            wrap_n = (s1_idx == '0);
          end
        end
        FAULT: begin
          if (s1_legal) begin
            ref_n   = s1_idx;
            cnt_n   = CNT_W'(1);
            state_n = UNLOCK;
          end
        end
        default: state_n = UNLOCK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= UNLOCK;
      ref_idx         <= '0;
      lock_cnt        <= '0;
      bus.phase_idx   <= '0;
      bus.phase_valid <= 1'b0;
      bus.wrap        <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_skip    <= 1'b0;
      bus.err_cnt     <= '0;
    end else begin
      state           <= state_n;
      ref_idx         <= ref_n;
      lock_cnt        <= cnt_n;
      bus.phase_idx   <= idx_n;
      bus.phase_valid <= pv_n;
      bus.wrap        <= wrap_n;
      bus.err_illegal <= ill_n;
      bus.err_skip    <= skip_n;
      bus.err_cnt     <= err_cnt_n;
    end
  end

  assign bus.locked = (state == TRACK);

`ifdef JC_PHASE_ONEHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.phase_onehot <= '0;
    end else begin
      bus.phase_onehot <= pv_n ? ((2*W)'(1) << idx_n) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_jc_phase_decoder.sv
// Directed bench for jc_phase_decoder (W=64, LOCK_CNT=4, ERR_W=8).
module tb_jc_phase_decoder;
  localparam int unsigned W     = 64;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned N     = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jc_phase_decoder_if #(.W(W), .ERR_W(ERR_W)) ifc ();

  jc_phase_decoder #(.W(W), .LOCK_CNT(4), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Johnson word for phase k: k ones entering from the MSB, then draining out.
  function automatic logic [W-1:0] jw(input int unsigned k);
    logic [W-1:0] ones;
    int unsigned  kk;
    ones = '1;
    kk   = k % N;
    if (kk == 0) return '0;
    if (kk <= W) return ~(ones >> kk);
    return ones >> (kk - W);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] q);
    ifc.jc_valid = v;
    ifc.jc_q     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, jw(5));
    step(1'b1, jw(6));
    n_chk++;
    if ({ifc.phase_valid, ifc.locked, ifc.wrap, ifc.err_illegal, ifc.err_skip} !== 5'b0 ||
        ifc.phase_idx !== '0 || ifc.err_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: pv=%b lk=%b idx=%0d cnt=%0d, required all 0",
               ifc.phase_valid, ifc.locked, ifc.phase_idx, ifc.err_cnt);
    end
    ifc.jc_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_lock();
    for (int k = 0; k <= 20; k++) begin
      step(1'b1, jw(k));
      if (k >= 1) begin
        logic exp_lk;
        exp_lk = (k - 1) >= 3;
        n_chk++;
        if (ifc.locked !== exp_lk || ifc.phase_valid !== exp_lk ||
            (exp_lk && ifc.phase_idx !== 7'(k - 1)) ||
            ifc.err_illegal !== 1'b0 || ifc.err_skip !== 1'b0 || ifc.wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL lock_seq k=%0d: lk=%b pv=%b idx=%0d, required lk=pv=%b idx=%0d",
                   k - 1, ifc.locked, ifc.phase_valid, ifc.phase_idx, exp_lk, k - 1);
        end
`ifdef JC_PHASE_ONEHOT_EN
        begin
          logic [N-1:0] oh;
          oh = '0;
          if (exp_lk) oh[k-1] = 1'b1;
          n_chk++;
          if (ifc.phase_onehot !== oh) begin
            n_fail++;
            $display("FAIL onehot k=%0d: got %h required %h", k - 1, ifc.phase_onehot, oh);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_wrap();
    int n_wrap;
    n_wrap = 0;
    for (int k = 21; k <= 130; k++) begin
      int unsigned e;
      step(1'b1, jw(k));
      e = (k - 1) % N;
      if (ifc.wrap === 1'b1) n_wrap++;
      n_chk++;
      if (ifc.phase_valid !== 1'b1 || ifc.phase_idx !== 7'(e) || ifc.wrap !== (e == 0) ||
          ifc.err_illegal !== 1'b0 || ifc.err_skip !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_seq e=%0d: pv=%b idx=%0d wrap=%b, required pv=1 idx=%0d wrap=%b",
                 e, ifc.phase_valid, ifc.phase_idx, ifc.wrap, e, e == 0);
      end
    end
    n_chk++;
    if (n_wrap != 1) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d required 1", n_wrap);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 64'h00FF00FF00FF00FF);
    step(1'b1, jw(3));
    n_chk++;
    if (ifc.err_illegal !== 1'b1 || ifc.err_skip !== 1'b0 || ifc.err_cnt !== 8'd1 ||
        ifc.locked !== 1'b0 || ifc.phase_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_hit: ill=%b skip=%b cnt=%0d lk=%b pv=%b, required 1 0 1 0 0",
               ifc.err_illegal, ifc.err_skip, ifc.err_cnt, ifc.locked, ifc.phase_valid);
    end
    for (int k = 4; k <= 10; k++) begin
      logic exp_lk;
      step(1'b1, jw(k));
      exp_lk = (k - 1) >= 6;
      n_chk++;
      if (ifc.locked !== exp_lk || ifc.err_illegal !== 1'b0 || ifc.err_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL illegal_relock idx=%0d: lk=%b ill=%b cnt=%0d, required lk=%b ill=0 cnt=1",
                 k - 1, ifc.locked, ifc.err_illegal, ifc.err_cnt, exp_lk);
      end
    end
  endtask

  task automatic test_skip();
    step(1'b1, jw(20));
    n_chk++;
    if (ifc.phase_valid !== 1'b1 || ifc.phase_idx !== 7'd10) begin
      n_fail++;
      $display("FAIL skip_pre: pv=%b idx=%0d, required pv=1 idx=10", ifc.phase_valid, ifc.phase_idx);
    end
    step(1'b1, jw(21));
    n_chk++;
    if (ifc.err_skip !== 1'b1 || ifc.err_illegal !== 1'b0 || ifc.err_cnt !== 8'd2 ||
        ifc.locked !== 1'b0 || ifc.phase_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_hit: skip=%b ill=%b cnt=%0d lk=%b pv=%b, required 1 0 2 0 0",
               ifc.err_skip, ifc.err_illegal, ifc.err_cnt, ifc.locked, ifc.phase_valid);
    end
    for (int k = 22; k <= 25; k++) begin
      logic exp_lk;
      step(1'b1, jw(k));
      exp_lk = (k - 1) >= 24;
      n_chk++;
      if (ifc.locked !== exp_lk || ifc.err_skip !== 1'b0 || ifc.err_cnt !== 8'd2) begin
        n_fail++;
        $display("FAIL skip_relock idx=%0d: lk=%b skip=%b cnt=%0d, required lk=%b skip=0 cnt=2",
                 k - 1, ifc.locked, ifc.err_skip, ifc.err_cnt, exp_lk);
      end
    end
  endtask

  task automatic test_gap();
    step(1'b1, jw(26));
    for (int g = 0; g < 6; g++) begin
      logic exp_pv;
      if (g < 5) step(1'b0, '0);
      else       step(1'b1, jw(27));
      exp_pv = (g == 0);
      n_chk++;
      if (ifc.phase_valid !== exp_pv || (exp_pv && ifc.phase_idx !== 7'd26) ||
          ifc.locked !== 1'b1 || ifc.err_skip !== 1'b0 || ifc.err_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL gap g=%0d: pv=%b lk=%b skip=%b ill=%b, required pv=%b lk=1 no err",
                 g, ifc.phase_valid, ifc.locked, ifc.err_skip, ifc.err_illegal, exp_pv);
      end
    end
    step(1'b1, jw(28));
    n_chk++;
    if (ifc.phase_valid !== 1'b1 || ifc.phase_idx !== 7'd27 || ifc.locked !== 1'b1 ||
        ifc.err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL gap_resume: pv=%b idx=%0d lk=%b cnt=%0d, required 1 27 1 2",
               ifc.phase_valid, ifc.phase_idx, ifc.locked, ifc.err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ifc.phase_valid, ifc.locked, ifc.wrap, ifc.err_illegal, ifc.err_skip} !== 5'b0 ||
        ifc.phase_idx !== '0 || ifc.err_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: pv=%b lk=%b idx=%0d cnt=%0d, required all 0",
               ifc.phase_valid, ifc.locked, ifc.phase_idx, ifc.err_cnt);
    end
    step(1'b0, '0);
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      int unsigned b;
      b = (i * 7) % N;
      for (int j = 0; j < 5; j++) begin
        step(1'b1, jw(j < 4 ? b + j : b + 40));
        if (j == 0 && i > 0) begin
          int unsigned exp_c;
          exp_c = (i > 255) ? 255 : i;
          n_chk++;
          if (ifc.err_skip !== 1'b1 || ifc.err_cnt !== 8'(exp_c)) begin
            n_fail++;
            $display("FAIL sat_cnt i=%0d: skip=%b cnt=%0d, required skip=1 cnt=%0d",
                     i, ifc.err_skip, ifc.err_cnt, exp_c);
          end
        end
        if (j >= 1) begin
          n_chk++;
          if (ifc.locked !== (j == 4)) begin
            n_fail++;
            $display("FAIL sat_lock i=%0d j=%0d: lk=%b required %b", i, j, ifc.locked, j == 4);
          end
        end
      end
    end
    step(1'b0, '0);
    n_chk++;
    if (ifc.err_skip !== 1'b1 || ifc.err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: skip=%b cnt=%0d, required skip=1 cnt=255", ifc.err_skip, ifc.err_cnt);
    end
  endtask

  initial begin
    ifc.jc_valid = 1'b0;
    ifc.jc_q     = '0;
    test_reset();
    test_lock();
    test_wrap();
    test_illegal();
    test_skip();
    test_gap();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
